toggle_scan_arbiter: RTL and testbench
======================================

Name: toggle_scan_arbiter

Overview:
- Shared serial transition-detection engine with a round-robin front end.
- NREQ requesters each offer a WIDTH-bit word over a valid/ready handshake. The block grants one requester, serialises the word LSB-first on a bit stream, and counts bit-to-bit transitions (Mealy edge-detect rule).
- Returns the count tagged with the requester id over a valid/ready result port.
- Sits between word producers and the serial edge-detection datapath; it sequences that resource and shares it between requesters.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, bits per word (2..32)
- CNT_W, 4, transition counter width; must satisfy 2^CNT_W > WIDTH-1
- IDW, 2, requester id width; must satisfy 2^IDW >= NREQ

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*WIDTH  word i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot grant/accept, combinational, IDLE only
- ser_bit  out  1  current serialised bit (registered)
- ser_valid  out  1  ser_bit is meaningful this cycle
- res_valid  out  1  result available
- res_ready  in  1  result consumer accept
- res_id  out  IDW  requester index of the result
- res_count  out  CNT_W  number of transitions in the word
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high) forces these values:
  - state=IDLE, last_grant=NREQ-1 (requester 0 has first priority)
  - req_ready=0, ser_bit=0, ser_valid=0, res_valid=0, res_id=0, res_count=0, busy=0
- FSM states:
  - IDLE:
    - Round-robin search starts at last_grant+1, wraps modulo NREQ, and takes the first requester with req_valid=1.
    - req_ready[g]=1 in the same cycle (combinational). All other bits of req_ready are 0.
    - On that edge: capture req_data word g into the shift register, set last_grant=g, clear the counter, go to SHIFT.
    - If no req_valid is set, stay in IDLE and keep req_ready=0.
  - SHIFT:
    - Lasts exactly WIDTH cycles. Each cycle: ser_bit=shreg[0], ser_valid=1, shift right.
    - Bit k (k>=1) increments the counter iff bit k != bit k-1. Bit 0 never counts.
    - After bit WIDTH-1, go to REPORT.
  - REPORT:
    - res_valid=1, res_id=last_grant, res_count=final count, ser_valid=0.
    - res_id and res_count stay stable while res_ready=0.
    - On an edge with res_valid&&res_ready: res_valid=0, go to IDLE.
- Latency: handshake at edge T; ser_valid=1 for cycles T+1..T+WIDTH; res_valid=1 from cycle T+WIDTH+1.
- Minimum occupancy is WIDTH+2 cycles per word, including one IDLE arbitration cycle.
- No new grant is issued while busy=1. Requesters hold req_valid and data until req_ready is seen.
- Simultaneous requests: only one grant per IDLE cycle. Fairness: with all requesters continuously valid, the grant order is 0,1,...,NREQ-1,0,...
- A requester dropping req_valid before its grant is legal and is simply skipped.
- Counter saturation cannot occur given the CNT_W rule.
- Reset mid-SHIFT or mid-REPORT aborts the word: no result is produced and the pointer returns to NREQ-1.

Optional Feature:
- Macro: TOGGLE_SCAN_PARITY_EN.
- Defined:
  - Adds output res_parity (1 bit) = XOR of all WIDTH bits of the granted word.
  - Accumulated during SHIFT; valid with res_valid; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Requester 0 sends 8'hB8 (10111000) → ser_bit sequence 0,0,0,1,1,1,0,1; res_valid at cycle T+9; res_id=0, res_count=3; with macro, res_parity=0.
- Requester 2 sends 8'hC7 (11000111) with res_ready=1 → res_id=2, res_count=2; with macro, res_parity=1.
- All four requesters valid at once with words 8'h55, 8'h00, 8'hFF, 8'h0F → results in order id 0,1,2,3 with counts 7,0,0,1.
- Result backpressure: res_ready=0 for 5 cycles after res_valid, while requester 1 stays valid → res_valid, res_id and res_count held; req_ready=0 throughout; requester 1 is granted in the cycle after acceptance.
- Reset pulse at cycle 3 of SHIFT → all outputs return to reset values immediately and no result appears. The next request from requester 0 completes normally, and requester 0 wins over requester 3 when both are valid.
- Back-to-back traffic: requester 3 continuously valid alone → grants every WIDTH+2 cycles with res_ready tied high; ser_valid low in the REPORT and IDLE cycles between words.

Source files
------------

// File: rtl/toggle_scan_arbiter.sv
// Round-robin front end sharing one serial transition counter between NREQ word producers.
// Optional macro TOGGLE_SCAN_PARITY_EN adds the res_parity result output.
module toggle_scan_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    ser_bit,
    output logic                    ser_valid,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [IDW-1:0]          res_id,
    output logic [CNT_W-1:0]        res_count,
    output logic                    busy
`ifdef TOGGLE_SCAN_PARITY_EN
    ,
    output logic                    res_parity
`endif
);

    localparam int IDXW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

    state_t            state;
    logic [IDW-1:0]    last_grant;
    logic [IDW-1:0]    gnt_idx;
    logic              gnt_found;
    logic [WIDTH-1:0]  gnt_word;
    logic [WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]  cnt;
    logic [IDXW-1:0]   bit_idx;
`ifdef TOGGLE_SCAN_PARITY_EN
    logic              par;
`endif

    // Scan priorities from lowest (k=NREQ) to highest (k=1) so the nearest
    // requester after last_grant is the one left standing.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_word  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && (i == (int'(last_grant) + k) % NREQ)) begin
                    gnt_found = 1'b1;
                    gnt_idx   = IDW'(i);
                    gnt_word  = req_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_found)
            req_ready = NREQ'(1) << gnt_idx;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            shreg      <= '0;
            cnt        <= '0;
            bit_idx    <= '0;
            ser_bit    <= 1'b0;
            ser_valid  <= 1'b0;
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_count  <= '0;
`ifdef TOGGLE_SCAN_PARITY_EN
            par        <= 1'b0;
            res_parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Bit 0 goes out on the grant edge itself, so the word
                    // occupies exactly WIDTH SHIFT cycles.
                    if (gnt_found) begin
                        shreg      <= gnt_word >> 1;
                        ser_bit    <= gnt_word[0];
                        ser_valid  <= 1'b1;
                        cnt        <= '0;
                        bit_idx    <= IDXW'(1);
                        last_grant <= gnt_idx;
`ifdef TOGGLE_SCAN_PARITY_EN
                        par        <= gnt_word[0];
`endif
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_idx == IDXW'(WIDTH)) begin
                        ser_valid  <= 1'b0;
                        res_valid  <= 1'b1;
                        res_id     <= last_grant;
                        res_count  <= cnt;
`ifdef TOGGLE_SCAN_PARITY_EN
                        res_parity <= par;
`endif
                        state      <= REPORT;
                    end else begin
                        ser_bit <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        if (shreg[0] != ser_bit)
                            cnt <= cnt + 1'b1;
`ifdef TOGGLE_SCAN_PARITY_EN
                        par     <= par ^ shreg[0];
`endif
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_scan_arbiter.sv
// Directed bench for toggle_scan_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_toggle_scan_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        ser_bit, ser_valid, res_valid, busy;
    logic        res_ready = 1'b1;
    logic [1:0]  res_id;
    logic [3:0]  res_count;
`ifdef TOGGLE_SCAN_PARITY_EN
    logic        res_parity;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    toggle_scan_arbiter #(.NREQ(4), .WIDTH(8), .CNT_W(4), .IDW(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .ser_bit(ser_bit), .ser_valid(ser_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_count(res_count), .busy(busy)
`ifdef TOGGLE_SCAN_PARITY_EN
        , .res_parity(res_parity)
`endif
    );

    typedef struct {
        int         id;
        logic [7:0] word;
        logic [3:0] cnt;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input int id);
        int n = 0;
        @(negedge clk);
        while (req_ready == 4'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_onehot", {28'd0, req_ready}, 32'd1 << id);
    endtask

    task automatic wait_result(input int id, input logic [3:0] cnt, input logic par);
        int n = 0;
        @(negedge clk);
        while (!res_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("res_valid_seen", {31'd0, res_valid}, 32'd1);
        check("res_id", {30'd0, res_id}, id);
        check("res_count", {28'd0, res_count}, {28'd0, cnt});
`ifdef TOGGLE_SCAN_PARITY_EN
        check("res_parity", {31'd0, res_parity}, {31'd0, par});
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'hB8, 4'd3, 1'b0};
        vecs[1] = '{2, 8'hC7, 4'd2, 1'b1};
        vecs[2] = '{1, 8'h55, 4'd7, 1'b0};
        vecs[3] = '{3, 8'h0F, 4'd1, 1'b0};
        vecs[4] = '{0, 8'hFF, 4'd0, 1'b0};
        vecs[5] = '{1, 8'h00, 4'd0, 1'b0};
        vecs[6] = '{2, 8'h01, 4'd1, 1'b1};
        vecs[7] = '{3, 8'hAA, 4'd7, 1'b0};

        // Reset values
        #1 reset = 1'b1;
        #2;
        check("reset_outputs", {22'd0, req_ready, ser_bit, ser_valid, res_valid, res_id, res_count},
              32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Table-driven single transactions
        for (int v = 0; v < 8; v++) begin
            @(posedge clk);
            #1;
            req_data[vecs[v].id*8 +: 8] = vecs[v].word;
            req_valid[vecs[v].id] = 1'b1;
            wait_grant(vecs[v].id);
            check("idle_busy", {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1 req_valid = '0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                check("ser_valid", {31'd0, ser_valid}, 32'd1);
                check("ser_bit", {31'd0, ser_bit}, {31'd0, vecs[v].word[k]});
            end
            @(negedge clk);
            check("res_valid", {31'd0, res_valid}, 32'd1);
            check("report_ser_valid", {31'd0, ser_valid}, 32'd0);
            check("res_id", {30'd0, res_id}, vecs[v].id);
            check("res_count", {28'd0, res_count}, {28'd0, vecs[v].cnt});
`ifdef TOGGLE_SCAN_PARITY_EN
            check("res_parity", {31'd0, res_parity}, {31'd0, vecs[v].par});
`endif
        end

        // All four requesters valid at once
        begin
            int got = 0, gcnt = 0, n = 0;
            int   exp_id[4]  = '{0, 1, 2, 3};
            int   exp_cnt[4] = '{7, 0, 0, 1};
            logic [3:0] rr;
            @(posedge clk);
            #1 req_data = {8'h0F, 8'hFF, 8'h00, 8'h55};
            req_valid = 4'hF;
            while (got < 4 && n < 80) begin
                @(negedge clk);
                rr = req_ready;
                if (rr != 4'd0) begin
                    check("rr_order", {28'd0, rr}, 32'd1 << gcnt);
                    gcnt++;
                end
                if (res_valid) begin
                    check("all4_id", {30'd0, res_id}, exp_id[got]);
                    check("all4_count", {28'd0, res_count}, exp_cnt[got]);
                    got++;
                end
                @(posedge clk);
                #1 req_valid = req_valid & ~rr;
                n++;
            end
            check("all4_results", got, 4);
        end

        // Result backpressure with requester 1 waiting
        @(posedge clk);
        #1 res_ready = 1'b0;
        req_data[7:0] = 8'h3C;
        req_valid = 4'b0001;
        wait_grant(0);
        @(posedge clk);
        #1 req_valid = 4'b0010;
        req_data[15:8] = 8'h81;
        wait_result(0, 4'd2, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_res_valid", {31'd0, res_valid}, 32'd1);
            check("bp_res_id", {30'd0, res_id}, 32'd0);
            check("bp_res_count", {28'd0, res_count}, 32'd2);
            check("bp_req_ready", {28'd0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk);
        check("bp_still_valid", {31'd0, res_valid}, 32'd1);
        @(negedge clk);
        check("bp_released", {31'd0, res_valid}, 32'd0);
        check("bp_next_grant", {28'd0, req_ready}, 32'b0010);
        @(posedge clk);
        #1 req_valid = '0;
        wait_result(1, 4'd2, 1'b0);

        // Reset in the middle of SHIFT
        @(posedge clk);
        #1 req_data[7:0] = 8'hB8;
        req_valid = 4'b0001;
        wait_grant(0);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midreset_outputs", {22'd0, req_ready, ser_bit, ser_valid, res_valid, res_id, res_count},
              32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        begin
            int seen = 0;
            for (int c = 0; c < 15; c++) begin
                @(negedge clk);
                if (res_valid || ser_valid) seen++;
            end
            check("aborted_no_result", seen, 0);
        end
        @(posedge clk);
        #1 req_data[7:0] = 8'hB8;
        req_data[31:24] = 8'h0F;
        req_valid = 4'b1001;
        wait_grant(0);
        @(posedge clk);
        #1 req_valid = 4'b1000;
        wait_result(0, 4'd3, 1'b0);
        wait_grant(3);
        @(posedge clk);
        #1 req_valid = '0;
        wait_result(3, 4'd1, 1'b0);

        // Back-to-back traffic from requester 3
        begin
            int last = -1, grants = 0;
            @(posedge clk);
            #1 req_data[31:24] = 8'hA5;
            req_valid = 4'b1000;
            for (int cyc = 0; cyc < 45; cyc++) begin
                @(negedge clk);
                if (req_ready[3]) begin
                    check("b2b_idle_ser_valid", {31'd0, ser_valid}, 32'd0);
                    if (last >= 0) check("b2b_spacing", cyc - last, 10);
                    last = cyc;
                    grants++;
                end else if (last >= 0 && cyc - last == 9) begin
                    check("b2b_report_ser_valid", {31'd0, ser_valid}, 32'd0);
                    check("b2b_report_res", {26'd0, res_valid, res_id, res_count}, {26'd0, 1'b1, 2'd3, 4'd6});
                end else if (last >= 0 && cyc - last >= 1 && cyc - last <= 8) begin
                    check("b2b_ser_valid", {31'd0, ser_valid}, 32'd1);
                end
            end
            check("b2b_grants", grants, 5);
            @(posedge clk);
            #1 req_valid = '0;
        end

        repeat (12) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
